spi_ram_ctrl: RTL

//  Parametrised single-port RAM sitting behind the SPI slave, next generation of the 8-bit/256-word RAM.
//  - Accepts {cmd[1:0], payload} words from the SPI slave: write-addr, write-data, read-addr, read-data.
//  - Returns read data with a one-cycle tx_valid strobe.
//  - Adds over the previous RAM: width/depth parameters, independent write/read address pointers,
//    a read-before-address error flag and an optional address auto-increment burst mode.

---
 rtl/spi_ram_pkg.sv | 14 +
 rtl/spi_ram_mem.sv | 26 ++
 rtl/spi_ram_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encoding for the SPI-side RAM controller.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Synchronous single-port RAM: registered write and registered read on the same address port.
module spi_ram_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read happens every edge; the controller only consumes it when it launched a fetch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder, address pointers and read FSM in front of spi_ram_mem.
// Define SPI_RAM_AUTO_INC_EN to make both pointers post-increment for burst access.
module spi_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  cmd_err
);

    import spi_ram_pkg::*;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_addr_vld_q, rd_addr_vld_d;
    logic                  cmd_err_q, cmd_err_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
`endif

    assign cmd     = din[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = din[DATA_WIDTH-1:0];

    always_comb begin
        state_d       = ST_IDLE;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        rd_addr_vld_d = rd_addr_vld_q;
        cmd_err_d     = 1'b0;
        // Capture the fetched word at the end of FETCH so it persists after the strobe.
        dout_d        = (state_q == ST_FETCH) ? mem_rdata : dout_q;
        mem_we        = 1'b0;
        mem_addr      = rd_addr_q;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = payload[ADDR_WIDTH-1:0];
                end
                CMD_WR_DATA: begin
                    mem_we   = 1'b1;
                    mem_addr = wr_addr_q;
`ifdef SPI_RAM_AUTO_INC_EN
                    wr_addr_d = wr_addr_q + ADDR_ONE;
`endif
                end
                CMD_RD_ADDR: begin
                    rd_addr_d     = payload[ADDR_WIDTH-1:0];
                    rd_addr_vld_d = 1'b1;
                end
                default: begin
                    // The array samples rd_addr_q on this edge, so the bump cannot disturb the fetch.
                    if (rd_addr_vld_q) begin
                        state_d = ST_FETCH;
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_addr_d = rd_addr_q + ADDR_ONE;
`endif
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_addr_vld_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            dout_q        <= '0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            cmd_err_q     <= cmd_err_d;
            dout_q        <= dout_d;
        end
    end

    spi_ram_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(payload),
        .rdata(mem_rdata)
    );

    // The strobe is the FETCH state itself, so an async reset removes it at once.
    assign tx_valid = (state_q == ST_FETCH);
    assign dout     = (state_q == ST_FETCH) ? mem_rdata : dout_q;
    assign cmd_err  = cmd_err_q;

endmodule
